// File: rtl/arith_pkg.sv
// Shared encodings for the sliced add/subtract datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : arith_pkg

// File: rtl/cla_block.sv
// Combinational carry-lookahead adder slice of BUS_WIDTH bits.
module cla_block #(
    parameter int unsigned BUS_WIDTH = 4
) (
    input  logic [BUS_WIDTH-1:0] i_a,
    input  logic [BUS_WIDTH-1:0] i_b,
    input  logic                 i_cin,
    output logic [BUS_WIDTH-1:0] o_sum,
    output logic                 o_cout
);

    logic [BUS_WIDTH-1:0] w_g;
    logic [BUS_WIDTH-1:0] w_p;
    logic [BUS_WIDTH:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is expanded from generate/propagate terms, never from a lower carry.
    always_comb begin
        logic v_acc;
        logic v_prop;
        w_c = '0;
        for (int i = 0; i <= int'(BUS_WIDTH); i++) begin
            v_acc  = 1'b0;
            v_prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                v_acc  = v_acc | (v_prop & w_g[j]);
                v_prop = v_prop & w_p[j];
            end
            w_c[i] = v_acc | (v_prop & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[BUS_WIDTH-1:0];
    assign o_cout = w_c[BUS_WIDTH];

endmodule : cla_block

// File: rtl/seq_addsub.sv
// Wide adder/subtractor that walks one CHUNK_WIDTH slice per cycle, LSB slice first,
// with valid/ready handshakes on operands and result.
module seq_addsub
    import arith_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout,
    output logic                  overflow
);

    localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if ((CHUNK_WIDTH == 0) || (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_width
            $error("seq_addsub: DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
        end
    endgenerate

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_s;
    logic                    r_carry;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_cout;
    logic                    r_ovf;

    logic [CHUNK_WIDTH-1:0]  w_a_slice;
    logic [CHUNK_WIDTH-1:0]  w_b_slice;
    logic [CHUNK_WIDTH-1:0]  w_sum;
    logic                    w_c;
    logic                    w_ovf;

    // Select the operand slice addressed by the current index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_slice = r_a[i*CHUNK_WIDTH +: CHUNK_WIDTH];
                w_b_slice = r_b[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    cla_block #(
        .BUS_WIDTH (CHUNK_WIDTH)
    ) u_cla (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_c)
    );

    // Only meaningful on the top slice, where the operand MSBs live.
    assign w_ovf = (w_a_slice[CHUNK_WIDTH-1] == w_b_slice[CHUNK_WIDTH-1]) &&
                   (w_sum[CHUNK_WIDTH-1] != w_a_slice[CHUNK_WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in1;
                        r_b        <= (op == OP_SUB) ? ~in2 : in2;
                        r_carry    <= op;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_s[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_sum;
                        end
                    end
                    r_carry <= w_c;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_c;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule : seq_addsub

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed corners, backpressure, mid-op reset, random ops.
module tb_seq_addsub;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NC = DW / CW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          op        = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in1       = '0;
    logic [DW-1:0] in2       = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] s;
    logic          cout;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    seq_addsub #(
        .DATA_WIDTH  (DW),
        .CHUNK_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic; returns {overflow, cout, s}.
    function automatic logic [DW+1:0] model(input logic o, input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0]   wide;
        logic [DW-1:0] r;
        logic          c;
        logic          v;
        if (!o) begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[DW-1:0];
            c    = wide[DW];
            v    = (x[DW-1] == y[DW-1]) && (r[DW-1] != x[DW-1]);
        end else begin
            r = x - y;
            c = (x >= y);
            v = (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
        end
        return {v, c, r};
    endfunction

    // Issue one operation and collect its result; lat counts edges from input to output handshake.
    task automatic do_op(input logic o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         output logic [DW-1:0] rs, output logic rc, output logic rv, output int lat);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL in_ready_timeout got=%b want=1", in_ready);
        end
        in_valid = 1'b1; op = o; in1 = x; in2 = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 1'($urandom); in1 = $urandom; in2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s; rc = cout; rv = overflow;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({out_valid, s, cout, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got ov=%b s=%h c=%b v=%b want all 0", out_valid, s, cout, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic          t_op [5];
        logic [DW-1:0] t_a  [5];
        logic [DW-1:0] t_b  [5];
        logic [DW+1:0] t_exp[5];
        logic [DW-1:0] rs;
        logic          rc, rv;
        logic [DW+1:0] exp_m;
        int            lat;
        t_op = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t_a  = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        t_b  = '{32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0001, 32'h1111_1111};
        t_exp = '{{1'b0, 1'b1, 32'h0000_0000}, {1'b0, 1'b0, 32'hFFFF_FFFE},
                  {1'b1, 1'b0, 32'h8000_0000}, {1'b1, 1'b1, 32'h7FFF_FFFF},
                  {1'b0, 1'b0, 32'h2345_6789}};
        for (int i = 0; i < 5; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], rs, rc, rv, lat);
            exp_m = t_exp[i];
            n_vec++;
            if ({rv, rc, rs} !== exp_m) begin
                n_err++;
                $display("FAIL directed_%0d got v=%b c=%b s=%h want v=%b c=%b s=%h",
                         i, rv, rc, rs, exp_m[DW+1], exp_m[DW], exp_m[DW-1:0]);
            end
            n_vec++;
            if (lat != int'(NC)) begin
                n_err++;
                $display("FAIL directed_latency_%0d got=%0d want=%0d", i, lat, NC);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW+1:0] e1, e2;
        int            lat;
        e1 = model(1'b0, 32'h0000_1234, 32'h0000_0FFF);
        e2 = model(1'b1, 32'hCAFE_0000, 32'h0BAD_F00D);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 1'b0; in1 = 32'h0000_1234; in2 = 32'h0000_0FFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat != int'(NC)) begin
            n_err++;
            $display("FAIL bp_latency got=%0d want=%0d", lat, NC);
        end
        in_valid = 1'b1; op = 1'b1; in1 = 32'hCAFE_0000; in2 = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({overflow, cout, s} !== e1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d got v=%b c=%b s=%h rdy=%b ov=%b want v=%b c=%b s=%h rdy=0 ov=1",
                         i, overflow, cout, s, in_ready, out_valid, e1[DW+1], e1[DW], e1[DW-1:0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_after_handshake got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept got in_ready=%b want 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if ({overflow, cout, s} !== e2 || lat != int'(NC)) begin
            n_err++;
            $display("FAIL bp_next_op got v=%b c=%b s=%h lat=%0d want v=%b c=%b s=%h lat=%0d",
                     overflow, cout, s, lat, e2[DW+1], e2[DW], e2[DW-1:0], NC);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rs;
        logic          rc, rv;
        int            lat;
        in_valid = 1'b1; op = 1'b0; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (out_valid !== 1'b0 || s !== '0) begin
            n_err++;
            $display("FAIL midreset_during got out_valid=%b s=%h want 0/0", out_valid, s);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        do_op(1'b0, 32'h1234_5678, 32'h1111_1111, rs, rc, rv, lat);
        n_vec++;
        if (rs !== 32'h2345_6789 || rc !== 1'b0 || rv !== 1'b0 || lat != int'(NC)) begin
            n_err++;
            $display("FAIL midreset_followup got s=%h c=%b v=%b lat=%0d want s=23456789 c=0 v=0 lat=%0d",
                     rs, rc, rv, lat, NC);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] corners[5];
        logic [DW-1:0] x, y, rs;
        logic          o, rc, rv;
        logic [DW+1:0] e;
        int            lat;
        corners = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 1000; i++) begin
            o = 1'($urandom);
            x = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : DW'($urandom);
            y = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : DW'($urandom);
            e = model(o, x, y);
            do_op(o, x, y, rs, rc, rv, lat);
            n_vec++;
            if ({rv, rc, rs} !== e) begin
                n_err++;
                $display("FAIL random_%0d op=%b a=%h b=%h got v=%b c=%b s=%h want v=%b c=%b s=%h",
                         i, o, x, y, rv, rc, rs, e[DW+1], e[DW], e[DW-1:0]);
            end
            n_vec++;
            if (lat != int'(NC)) begin
                n_err++;
                $display("FAIL random_latency_%0d got=%0d want=%0d", i, lat, NC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_addsub
